// File: rtl/imm_ext_pkg.sv
// Shared encodings and default widths for the immediate-extension stage.
package imm_ext_pkg;
  localparam int IMM_IN_W  = 16;
  localparam int IMM_OUT_W = 32;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'd0,
    EXT_SIGN  = 2'd1,
    EXT_LUI   = 2'd2,
    EXT_SHAMT = 2'd3
  } ext_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;
endpackage

// File: rtl/imm_extender.sv
// Pure combinational immediate extension: zero, sign, LUI (upper half) or
// MIPS shamt field (imm[10:6]).
module imm_extender
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] ext_o
);
  always_comb begin
    ext_o = '0;
    case (mode_i)
      EXT_ZERO:  ext_o[IN_W-1:0]      = imm_i;
      EXT_SIGN:  ext_o                = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
      EXT_LUI:   ext_o[2*IN_W-1:IN_W] = imm_i;
      EXT_SHAMT: ext_o[4:0]           = imm_i[10:6];
      default:   ext_o                = '0;
    endcase
  end
endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer and flush.
// Optional stall counter output enabled by IMM_EXT_STAGE_STATS_EN.
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       ext_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic             imm_neg
`ifdef IMM_EXT_STAGE_STATS_EN
  ,output logic [15:0]     stall_cnt
`endif
);
  state_e           state_q, state_d;
  logic [OUT_W-1:0] main_q, main_d, skid_q, skid_d, ext_val;
  logic             in_x, out_x;

  imm_extender #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ext (
    .imm_i  (imm_in),
    .mode_i (ext_mode),
    .ext_o  (ext_val)
  );

  assign in_x  = in_valid && in_ready;
  assign out_x = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_x) state_d = ST_ONE;
        ST_ONE: begin
          if (in_x && !out_x)      state_d = ST_TWO;
          else if (!in_x && out_x) state_d = ST_EMPTY;
        end
        ST_TWO:   if (out_x) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready depends only on the state register, never on out_ready.
  always_comb begin
    in_ready  = (state_q != ST_TWO);
    out_valid = (state_q != ST_EMPTY);
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: if (in_x) main_d = ext_val;
        ST_ONE: begin
          if (in_x && out_x) main_d = ext_val;
          else if (in_x)     skid_d = ext_val;
        end
        ST_TWO:   if (out_x) main_d = skid_q;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign imm_out = main_q;
  assign imm_neg = main_q[OUT_W-1];

`ifdef IMM_EXT_STAGE_STATS_EN
  logic [15:0] stall_q;

  // Saturating; flush intentionally leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_imm_ext_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, imm_neg;
  logic [15:0] imm_in;
  logic [1:0]  ext_mode;
  logic [31:0] imm_out;
`ifdef IMM_EXT_STAGE_STATS_EN
  logic [15:0] stall_cnt;
`endif

  imm_ext_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_in    (imm_in),
    .ext_mode  (ext_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .imm_neg   (imm_neg)
`ifdef IMM_EXT_STAGE_STATS_EN
    ,.stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] mq[$];
  logic [31:0] last_m = '0;
  int unsigned stall_m = 0;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[8];

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int unsigned v = 32'(imm);
    case (mode)
      2'd0:    return v;
      2'd1:    return (v >= 32768) ? v - 65536 : v;
      2'd2:    return v * 65536;
      default: return (v / 64) % 32;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
    chk("imm_out",   imm_out, last_m);
    chk("imm_neg",   32'(imm_neg), 32'(last_m[31]));
`ifdef IMM_EXT_STAGE_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), stall_m);
`endif
  endtask

  // Called at a negedge: drive, advance the model across the posedge, check.
  task automatic cyc(input logic iv, input logic [15:0] imm, input logic [1:0] mode,
                     input logic ordy, input logic fl);
    logic inx, outx;
    logic [31:0] e;
    in_valid = iv; imm_in = imm; ext_mode = mode; out_ready = ordy; flush = fl;
    inx  = iv && (mq.size() < 2);
    outx = (mq.size() > 0) && ordy;
    if (mq.size() > 0 && !ordy && stall_m < 65535) stall_m++;
    e = ref_ext(imm, mode);
    @(posedge clk);
    if (outx) void'(mq.pop_front());
    if (fl) mq.delete();
    else if (inx) mq.push_back(e);
    if (mq.size() > 0) last_m = mq[0];
    @(negedge clk);
    check_state();
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 16'h0, 2'd0, ordy, 1'b0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    mq.delete(); last_m = '0; stall_m = 0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_imm_out",   imm_out, 32'd0);
    chk("rst_imm_neg",   32'(imm_neg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{16'h8001, 2'd1, 32'hFFFF8001};
    vt[1] = '{16'h8001, 2'd0, 32'h00008001};
    vt[2] = '{16'h1234, 2'd2, 32'h12340000};
    vt[3] = '{16'h07C0, 2'd3, 32'h0000001F};
    vt[4] = '{16'h7FFF, 2'd1, 32'h00007FFF};
    vt[5] = '{16'hFFFF, 2'd2, 32'hFFFF0000};
    vt[6] = '{16'hFFFF, 2'd3, 32'h0000001F};
    vt[7] = '{16'h0000, 2'd1, 32'h00000000};

    rst_n = 1'b0; in_valid = 1'b0; imm_in = '0; ext_mode = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_in_ready",  32'(in_ready),  32'd1);
    chk("init_imm_out",   imm_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    // Extension table, one beat per cycle with the sink always ready
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, vt[i].imm, vt[i].mode, 1'b1, 1'b0);
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_value", imm_out, vt[i].exp);
      chk("tbl_neg",   32'(imm_neg), 32'(vt[i].exp[31]));
    end
    idle(1'b1);

    // Eight back-to-back beats
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'($urandom), 2'(i), 1'b1, 1'b0);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    idle(1'b1);

    // Stall with A, B, C offered; release and drain in order
    cyc(1'b1, 16'h1111, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 2'd0, 1'b0, 1'b0);
    chk("abc_hold_a",  imm_out, 32'h00001111);
    chk("abc_full",    32'(in_ready), 32'd0);
    cyc(1'b1, 16'h3333, 2'd0, 1'b0, 1'b0);
    chk("abc_c_wait",  imm_out, 32'h00001111);
    cyc(1'b1, 16'h3333, 2'd0, 1'b1, 1'b0);
    chk("abc_b_main",  imm_out, 32'h00002222);
    cyc(1'b1, 16'h3333, 2'd0, 1'b1, 1'b0);
    chk("abc_c_main",  imm_out, 32'h00003333);
    idle(1'b1);
    chk("abc_drained", 32'(out_valid), 32'd0);

    // Flush while full with a beat offered: that beat must vanish
    cyc(1'b1, 16'h8AAA, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0BBB, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'hDEAD, 2'd0, 1'b0, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready),  32'd1);
    chk("flush_keep",  imm_out, 32'hFFFF8AAA);
    idle(1'b1);
    idle(1'b1);
    chk("flush_no_ghost", 32'(out_valid), 32'd0);

    // Flush coinciding with an output transfer
    cyc(1'b1, 16'h4321, 2'd2, 1'b1, 1'b0);
    cyc(1'b1, 16'h5555, 2'd0, 1'b1, 1'b1);
    chk("flush_xfer_empty", 32'(out_valid), 32'd0);
    chk("flush_xfer_keep",  imm_out, 32'h43210000);

`ifdef IMM_EXT_STAGE_STATS_EN
    async_reset();
    cyc(1'b1, 16'h0001, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
    chk("stats_three", 32'(stall_cnt), 32'd3);
    cyc(1'b0, 16'h0, 2'd0, 1'b0, 1'b1);
    chk("stats_survive_flush", 32'(stall_cnt), 32'd4);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));

    // Reset asserted mid-stream while full
    idle(1'b1);
    cyc(1'b1, 16'h0F0F, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'hF0F0, 2'd1, 1'b0, 1'b0);
    chk("pre_reset_full", 32'(in_ready), 32'd0);
    async_reset();
    idle(1'b1);
    cyc(1'b1, 16'h8001, 2'd1, 1'b1, 1'b0);
    chk("post_reset_beat", imm_out, 32'hFFFF8001);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
